// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - read/write/fill request front-end for the 32x32 register memory
// Optional feature: READBACK_VERIFY_EN (write followed by read-back compare).
module mem_req_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(READ_LAT + 1);

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;

`ifdef READBACK_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, FILL, VFY} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, FILL} state_t;
`endif

    state_t            state, state_d;
    logic [CNT_W-1:0]  lat_cnt;
    logic [ADDR_W:0]   fill_addr;
    logic [ADDR_W:0]   fill_cnt;
    logic              accept, lat_done, fill_done;

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_comb begin
        state_d   = state;
        accept    = req_valid && req_ready;
        lat_done  = (lat_cnt == CNT_W'(READ_LAT));
        fill_done = (fill_addr == (ADDR_W+1)'(DEPTH));
        case (state)
            IDLE: begin
                // Reserved op is answered straight from IDLE so back-to-back still holds.
                if (accept) begin
                    case (req_op)
                        OP_RD:   state_d = RD_WAIT;
                        OP_WR:   state_d = WR;
                        OP_FILL: state_d = FILL;
                        default: state_d = IDLE;
                    endcase
                end
            end
`ifdef READBACK_VERIFY_EN
            WR:      state_d = VFY;
            VFY:     if (lat_done) state_d = IDLE;
`else
            WR:      state_d = IDLE;
`endif
            RD_WAIT: if (lat_done) state_d = IDLE;
            FILL:    if (fill_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_mode  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_cnt   <= '0;
            fill_addr <= '0;
            fill_cnt  <= '0;
        end else begin
            state     <= state_d;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr <= req_addr;
                        case (req_op)
                            OP_RD: begin
                                mem_we   <= 1'b0;
                                mem_mode <= 1'b0;
                                lat_cnt  <= '0;
                            end
                            OP_WR: begin
                                mem_we    <= 1'b1;
                                mem_mode  <= 1'b1;
                                mem_wdata <= req_data;
                            end
                            OP_FILL: begin
                                mem_we    <= 1'b1;
                                mem_mode  <= 1'b1;
                                mem_wdata <= req_data;
                                fill_addr <= {1'b0, req_addr} + (ADDR_W+1)'(1);
                                fill_cnt  <= (ADDR_W+1)'(1);
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                WR: begin
                    mem_we   <= 1'b0;
                    mem_mode <= 1'b0;
`ifdef READBACK_VERIFY_EN
                    lat_cnt  <= '0;
`else
                    rsp_valid <= 1'b1;
`endif
                end
                RD_WAIT: begin
                    if (lat_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
`ifdef READBACK_VERIFY_EN
                // mem_wdata still holds the written word for the compare.
                VFY: begin
                    if (lat_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rdata;
                        rsp_err   <= (mem_rdata != mem_wdata);
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
`endif
                FILL: begin
                    if (fill_done) begin
                        mem_we    <= 1'b0;
                        mem_mode  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {{(DATA_W-ADDR_W-1){1'b0}}, fill_cnt};
                    end else begin
                        mem_addr  <= fill_addr[ADDR_W-1:0];
                        fill_addr <= fill_addr + (ADDR_W+1)'(1);
                        fill_cnt  <= fill_cnt + (ADDR_W+1)'(1);
                    end
                end
                default: begin
                    mem_we   <= 1'b0;
                    mem_mode <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - directed bench for mem_req_sequencer with a 2-stage read memory model
module tb_mem_req_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        mem_we;
    logic        mem_mode;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_req_sequencer #(.DATA_W(32), .ADDR_W(5), .READ_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, two-register read path (READ_LAT=2).
    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] r1 = '0, r2 = '0;
    int          wr_cnt = 0;
    int          mode_bad = 0;
    logic [31:0] flip;
`ifdef READBACK_VERIFY_EN
    assign flip = (mem_addr == 5'd7) ? 32'h1 : 32'h0;
`else
    assign flip = 32'h0;
`endif
    assign mem_rdata = r2;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        r1 <= mem[mem_addr] ^ flip;
        r2 <= r1;
        if (mem_mode !== mem_we) mode_bad <= mode_bad + 1;
    end

`ifdef READBACK_VERIFY_EN
    localparam int WR_LAT = 5;
`else
    localparam int WR_LAT = 2;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns in cycle 1 after accept.
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        check("req_ready_before_issue", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        req_addr  = 5'h1f;
        req_data  = 32'h5555_0000;
    endtask

    task automatic wait_rsp(input int maxc, output int n);
        n = 1;
        while (rsp_valid !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    int n, w0, seen;

    initial begin
        // 1. reset and single write
        tick(); tick();
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_mem_addr", mem_addr, 5'd0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_req_ready", req_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        w0 = wr_cnt;
        issue(2'b01, 5'd5, 32'hDEADBEEF);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_mode", mem_mode, 1'b1);
        check("wr_mem_addr", mem_addr, 5'd5);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_busy", busy, 1'b1);
        wait_rsp(12, n);
        check("wr_latency", n, WR_LAT);
        check("wr_rsp_err", rsp_err, 1'b0);
`ifdef READBACK_VERIFY_EN
        check("wr_rsp_data", rsp_data, 32'hDEADBEEF);
`else
        check("wr_rsp_data", rsp_data, 32'h0);
`endif
        check("wr_single_write", wr_cnt - w0, 1);
        check("wr_mem5", mem[5], 32'hDEADBEEF);

        // 2. read back
        tick();
        w0 = wr_cnt;
        issue(2'b00, 5'd5, 32'h0);
        check("rd_mem_addr", mem_addr, 5'd5);
        check("rd_mem_we", mem_we, 1'b0);
        wait_rsp(12, n);
        check("rd_latency", n, 4);
        check("rd_rsp_data", rsp_data, 32'hDEADBEEF);
        check("rd_rsp_err", rsp_err, 1'b0);
        check("rd_no_write", wr_cnt - w0, 0);

        // 3. fill to the top of memory, then back-to-back read
        tick();
        w0 = wr_cnt;
        issue(2'b10, 5'd28, 32'hA5A5A5A5);
        wait_rsp(20, n);
        check("fill_latency", n, 5);
        check("fill_rsp_data", rsp_data, 32'd4);
        check("fill_rsp_err", rsp_err, 1'b0);
        check("fill_write_count", wr_cnt - w0, 4);
        check("fill_mem_we_off", mem_we, 1'b0);
        check("fill_b2b_ready", req_ready, 1'b1);
        issue(2'b00, 5'd31, 32'h0);
        wait_rsp(12, n);
        check("b2b_rd_latency", n, 4);
        check("b2b_rd_data", rsp_data, 32'hA5A5A5A5);
        check("fill_mem28", mem[28], 32'hA5A5A5A5);
        check("fill_mem31", mem[31], 32'hA5A5A5A5);
        check("fill_mem0_untouched", mem[0], 32'h0);
        check("fill_mem27_untouched", mem[27], 32'h0);

        // 4. reserved op
        tick();
        w0 = wr_cnt;
        issue(2'b11, 5'd5, 32'h12345678);
        check("err_rsp_valid", rsp_valid, 1'b1);
        check("err_rsp_err", rsp_err, 1'b1);
        check("err_rsp_data", rsp_data, 32'h0);
        check("err_mem_we", mem_we, 1'b0);
        check("err_b2b_ready", req_ready, 1'b1);
        issue(2'b00, 5'd5, 32'h0);
        wait_rsp(12, n);
        check("err_rd_latency", n, 4);
        check("err_rd_data", rsp_data, 32'hDEADBEEF);
        check("err_no_write", wr_cnt - w0, 0);

        // 5. reset in the middle of a fill
        tick();
        issue(2'b10, 5'd0, 32'h11111111);
        n = 0;
        while (!(mem_we === 1'b1 && mem_addr === 5'd10) && n < 40) begin
            tick();
            n++;
        end
        check("abort_reached_addr10", n < 40, 1'b1);
        reset = 1'b1;
        tick();
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_ready_in_reset", req_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("abort_ready_after", req_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid === 1'b1 || mem_we === 1'b1) seen++;
        end
        check("abort_quiet", seen, 0);
        check("abort_mem10", mem[10], 32'h11111111);
        check("abort_mem11", mem[11], 32'h0);

`ifdef READBACK_VERIFY_EN
        // 6. read-back compare catches a flipped bit
        issue(2'b01, 5'd7, 32'h1);
        wait_rsp(12, n);
        check("vfy_latency", n, 5);
        check("vfy_rsp_err", rsp_err, 1'b1);
        check("vfy_rsp_data", rsp_data, 32'h0);
`endif

        check("mode_tracks_we", mode_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
